multicycle_control: RTL and testbench

- Parametrised multi-cycle control FSM for the RV32I core; the single-cycle decoder's successor.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Handshakes with instruction memory, data memory and an optional multiply/divide unit. Drives datapath enables and muxes from state plus the latched instruction.
- Adds LUI/AUIPC, all branch conditions, an illegal-instruction trap and cycle/instret counters.

---
 rtl/multicycle_control_pkg.sv | 90 +++++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control_alu_decoder.sv | 89 ++++++++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Holds opcodes, ALU codes, datapath mux selects and small decode helpers.
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_MD_WAIT,
      S_WB,
      S_TRAP
   } ctrl_state_t;

   typedef enum logic [3:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_LUI,
      CLS_AUIPC,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_MULDIV
   } instr_class_t;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [1:0] ALU_SRC_A_RS1  = 2'b00;
   localparam logic [1:0] ALU_SRC_A_PC   = 2'b01;
   localparam logic [1:0] ALU_SRC_A_ZERO = 2'b10;
   localparam logic       ALU_SRC_B_RS2  = 1'b0;
   localparam logic       ALU_SRC_B_IMM  = 1'b1;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JALR   = 2'b10;

   localparam logic [1:0] MEM_TO_REG_ALU    = 2'b00;
   localparam logic [1:0] MEM_TO_REG_LOAD   = 2'b01;
   localparam logic [1:0] MEM_TO_REG_LINK   = 2'b10;
   localparam logic [1:0] MEM_TO_REG_MULDIV = 2'b11;

   function automatic logic [3:0] baseAluOp(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [1:0] memToRegFor(input instr_class_t cls);
      case (cls)
         CLS_LOAD:          return MEM_TO_REG_LOAD;
         CLS_JAL, CLS_JALR: return MEM_TO_REG_LINK;
         CLS_MULDIV:        return MEM_TO_REG_MULDIV;
         default:           return MEM_TO_REG_ALU;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath/memory bundle; master is the control FSM side.
interface multicycle_control_if #(parameter int CNT_W = 32);

   logic [31:0]      instr;
   logic             imem_ready;
   logic             dmem_ready;
   logic             branch_taken;
   logic             muldiv_done;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic             muldiv_start;
   logic             ir_write;
   logic             pc_write;
   logic             reg_write;
   logic [1:0]       alu_src_a;
   logic             alu_src_b;
   logic [3:0]       alu_control;
   logic [1:0]       mem_to_reg;
   logic [1:0]       pc_src;
   logic             illegal_instr;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      input  instr, imem_ready, dmem_ready, branch_taken, muldiv_done,
      output imem_req, dmem_req, dmem_we, muldiv_start, ir_write, pc_write,
             reg_write, alu_src_a, alu_src_b, alu_control, mem_to_reg, pc_src,
             illegal_instr, cycle_cnt, instret_cnt
   );

   modport slave (
      output instr, imem_ready, dmem_ready, branch_taken, muldiv_done,
      input  imem_req, dmem_req, dmem_we, muldiv_start, ir_write, pc_write,
             reg_write, alu_src_a, alu_src_b, alu_control, mem_to_reg, pc_src,
             illegal_instr, cycle_cnt, instret_cnt
   );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational instruction classifier: ALU operation, instruction class and legality.
module alu_decoder
   import multicycle_control_pkg::*;
#(
   parameter bit HAS_M = 1'b0
) (
   input  logic [31:0]  instr_i,
   output logic [3:0]   aluControl_o,
   output logic         legal_o,
   output instr_class_t instrClass_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unusedInstrBits;

   assign opcode          = instr_i[6:0];
   assign funct3          = instr_i[14:12];
   assign funct7          = instr_i[31:25];
   assign unusedInstrBits = ^{instr_i[24:15], instr_i[11:7]};

   always_comb begin
      aluControl_o = ALU_ADD;
      legal_o      = 1'b0;
      instrClass_o = CLS_ALU_R;
      case (opcode)
         OP_R_TYPE: begin
            case (funct7)
               F7_BASE: begin
                  legal_o      = 1'b1;
                  aluControl_o = baseAluOp(funct3);
               end
               F7_ALT: begin
                  legal_o      = (funct3 == 3'b000) || (funct3 == 3'b101);
                  aluControl_o = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
               end
               F7_MULDIV: begin
                  legal_o      = HAS_M;
                  instrClass_o = CLS_MULDIV;
               end
               default: legal_o = 1'b0;
            endcase
         end
         OP_I_TYPE: begin
            legal_o      = 1'b1;
            instrClass_o = CLS_ALU_I;
            aluControl_o = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : baseAluOp(funct3);
         end
         OP_LUI: begin
            legal_o      = 1'b1;
            instrClass_o = CLS_LUI;
         end
         OP_AUIPC: begin
            legal_o      = 1'b1;
            instrClass_o = CLS_AUIPC;
         end
         OP_JAL: begin
            legal_o      = 1'b1;
            instrClass_o = CLS_JAL;
         end
         OP_JALR: begin
            legal_o      = 1'b1;
            instrClass_o = CLS_JALR;
         end
         OP_LOAD: begin
            legal_o      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            instrClass_o = CLS_LOAD;
         end
         OP_STORE: begin
            legal_o      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            instrClass_o = CLS_STORE;
         end
         OP_BRANCH: begin
            // beq/bne compare by subtraction; signed and unsigned pairs use set-less-than
            legal_o      = (funct3 != 3'b010) && (funct3 != 3'b011);
            instrClass_o = CLS_BRANCH;
            if (funct3[2:1] == 2'b00)
               aluControl_o = ALU_SUB;
            else if (funct3[1])
               aluControl_o = ALU_SLTU;
            else
               aluControl_o = ALU_SLT;
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory and mul/div handshakes, illegal-instruction trap and cycle/instret counters.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter bit HAS_M = 1'b0,
   parameter int CNT_W = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master ctrl
);

   ctrl_state_t      state_q, state_d;
   logic             illegal_q;
   logic [CNT_W-1:0] cycleCnt_q, instretCnt_q;
   logic             retire;
   logic [3:0]       aluControl;
   logic             instrLegal;
   instr_class_t     instrClass;

   alu_decoder #(.HAS_M(HAS_M)) u_alu_decoder (
      .instr_i      (ctrl.instr),
      .aluControl_o (aluControl),
      .legal_o      (instrLegal),
      .instrClass_o (instrClass)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == S_TRAP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt_q   <= '0;
         instretCnt_q <= '0;
      end else begin
         cycleCnt_q <= cycleCnt_q + CNT_W'(1);
         if (retire)
            instretCnt_q <= instretCnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:   if (ctrl.imem_ready) state_d = S_DECODE;
         S_DECODE:  state_d = instrLegal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            case (instrClass)
               CLS_LOAD, CLS_STORE: state_d = S_MEM;
               CLS_MULDIV:          state_d = S_MD_WAIT;
               CLS_BRANCH: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default:             state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (ctrl.dmem_ready) begin
               state_d = (instrClass == CLS_STORE) ? S_FETCH : S_WB;
               retire  = (instrClass == CLS_STORE);
            end
         end
         S_MD_WAIT: if (ctrl.muldiv_done) state_d = S_WB;
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase
   end

   // Datapath controls are gated by rst_n so an abandoned access drops immediately
   always_comb begin
      ctrl.imem_req     = 1'b0;
      ctrl.dmem_req     = 1'b0;
      ctrl.dmem_we      = 1'b0;
      ctrl.muldiv_start = 1'b0;
      ctrl.ir_write     = 1'b0;
      ctrl.pc_write     = 1'b0;
      ctrl.reg_write    = 1'b0;
      ctrl.alu_src_a    = ALU_SRC_A_RS1;
      ctrl.alu_src_b    = ALU_SRC_B_RS2;
      ctrl.alu_control  = ALU_ADD;
      ctrl.mem_to_reg   = MEM_TO_REG_ALU;
      ctrl.pc_src       = PC_SRC_PLUS4;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               ctrl.imem_req = 1'b1;
               ctrl.ir_write = ctrl.imem_ready;
               ctrl.pc_write = ctrl.imem_ready;
            end
            S_EXECUTE: begin
               ctrl.alu_control = aluControl;
               case (instrClass)
                  CLS_ALU_I, CLS_LOAD, CLS_STORE: ctrl.alu_src_b = ALU_SRC_B_IMM;
                  CLS_LUI: begin
                     ctrl.alu_src_a = ALU_SRC_A_ZERO;
                     ctrl.alu_src_b = ALU_SRC_B_IMM;
                  end
                  CLS_AUIPC: begin
                     ctrl.alu_src_a = ALU_SRC_A_PC;
                     ctrl.alu_src_b = ALU_SRC_B_IMM;
                  end
                  CLS_BRANCH: begin
                     ctrl.pc_write = ctrl.branch_taken;
                     ctrl.pc_src   = PC_SRC_BRANCH;
                  end
                  CLS_JAL: begin
                     ctrl.pc_write = 1'b1;
                     ctrl.pc_src   = PC_SRC_BRANCH;
                  end
                  CLS_JALR: begin
                     ctrl.alu_src_b = ALU_SRC_B_IMM;
                     ctrl.pc_write  = 1'b1;
                     ctrl.pc_src    = PC_SRC_JALR;
                  end
                  CLS_MULDIV: ctrl.muldiv_start = 1'b1;
                  default: ;
               endcase
            end
            S_MEM: begin
               ctrl.dmem_req = 1'b1;
               ctrl.dmem_we  = (instrClass == CLS_STORE);
            end
            S_WB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = memToRegFor(instrClass);
            end
            default: ;
         endcase
      end
   end

   assign ctrl.illegal_instr = illegal_q;
   assign ctrl.cycle_cnt     = cycleCnt_q;
   assign ctrl.instret_cnt   = instretCnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one HAS_M=1/CNT_W=32 instance and one
// HAS_M=0/CNT_W=4 instance driven by the same memory/datapath stimulus.
module tb_multicycle_control;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        imemReady;
      logic        dmemReady;
      logic        branchTaken;
      logic        muldivDone;
      logic [17:0] expOut;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        imemReady = 1'b0;
   logic        dmemReady = 1'b0;
   logic        branchTaken = 1'b0;
   logic        muldivDone = 1'b0;

   int   checks = 0;
   int   failures = 0;
   int   cycles = 0;
   vec_t vecs[$];

   logic [17:0] expFetch, expFetchWait, expIdle, expWbAlu, expWbLoad, expWbLink, expWbMd;

   multicycle_control_if #(.CNT_W(32)) busM ();
   multicycle_control_if #(.CNT_W(4))  busN ();

   assign busM.instr        = instr;
   assign busM.imem_ready   = imemReady;
   assign busM.dmem_ready   = dmemReady;
   assign busM.branch_taken = branchTaken;
   assign busM.muldiv_done  = muldivDone;
   assign busN.instr        = instr;
   assign busN.imem_ready   = imemReady;
   assign busN.dmem_ready   = dmemReady;
   assign busN.branch_taken = branchTaken;
   assign busN.muldiv_done  = muldivDone;

   multicycle_control #(.HAS_M(1'b1), .CNT_W(32)) dutM (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (busM.master)
   );

   multicycle_control #(.HAS_M(1'b0), .CNT_W(4)) dutN (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (busN.master)
   );

   always #5 clk = ~clk;

   // Field order: imem_req dmem_req dmem_we muldiv_start ir_write pc_write reg_write src_a src_b alu mem_to_reg pc_src
   function automatic logic [17:0] packOut(input logic imem, dreq, dwe, mds, irw, pcw, rw,
                                           input logic [1:0] sa, input logic sb,
                                           input logic [3:0] alu, input logic [1:0] m2r, pcs);
      return {imem, dreq, dwe, mds, irw, pcw, rw, sa, sb, alu, m2r, pcs};
   endfunction

   function automatic logic [17:0] exOut(input logic [1:0] sa, input logic sb, input logic [3:0] alu,
                                         input logic pcw, input logic [1:0] pcs);
      return packOut(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 1'b0, sa, sb, alu, 2'b00, pcs);
   endfunction

   function automatic logic [17:0] outsM();
      return {busM.imem_req, busM.dmem_req, busM.dmem_we, busM.muldiv_start, busM.ir_write,
              busM.pc_write, busM.reg_write, busM.alu_src_a, busM.alu_src_b, busM.alu_control,
              busM.mem_to_reg, busM.pc_src};
   endfunction

   function automatic logic [17:0] outsN();
      return {busN.imem_req, busN.dmem_req, busN.dmem_we, busN.muldiv_start, busN.ir_write,
              busN.pc_write, busN.reg_write, busN.alu_src_a, busN.alu_src_b, busN.alu_control,
              busN.mem_to_reg, busN.pc_src};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      instr       = v.instr;
      imemReady   = v.imemReady;
      dmemReady   = v.dmemReady;
      branchTaken = v.branchTaken;
      muldivDone  = v.muldivDone;
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      #1;
      checkOutput(v.name, {46'h0, outsM()}, {46'h0, v.expOut});
      @(negedge clk);
      cycles++;
   endtask

   function automatic vec_t mkVec(input string name, input logic [31:0] ins, input logic ir, dr, bt, md,
                                  input logic [17:0] e);
      vec_t v;
      v.name = name; v.instr = ins; v.imemReady = ir; v.dmemReady = dr;
      v.branchTaken = bt; v.muldivDone = md; v.expOut = e;
      return v;
   endfunction

   task automatic addVec(input string name, input logic [31:0] ins, input logic ir, dr, bt, md,
                         input logic [17:0] e);
      vecs.push_back(mkVec(name, ins, ir, dr, bt, md, e));
   endtask

   task automatic addAlu(input string name, input logic [31:0] ins, input logic [17:0] exExp);
      addVec({name, " fetch"}, ins, 1'b1, 1'b0, 1'b0, 1'b0, expFetch);
      addVec({name, " decode"}, ins, 1'b0, 1'b0, 1'b0, 1'b0, expIdle);
      addVec({name, " exec"}, ins, 1'b0, 1'b0, 1'b0, 1'b0, exExp);
      addVec({name, " wb"}, ins, 1'b0, 1'b0, 1'b0, 1'b0, expWbAlu);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      instr = 32'h002081B3;
      imemReady = 1'b1; dmemReady = 1'b1; branchTaken = 1'b1; muldivDone = 1'b1;
      #1;
      checkOutput("reset outsM", {46'h0, outsM()}, 64'h0);
      checkOutput("reset outsN", {46'h0, outsN()}, 64'h0);
      checkOutput("reset cntM", {busM.cycle_cnt, busM.instret_cnt}, 64'h0);
      checkOutput("reset illegal", {62'h0, busM.illegal_instr, busN.illegal_instr}, 64'h0);
      repeat (2) @(negedge clk);
      imemReady = 1'b0; dmemReady = 1'b0; branchTaken = 1'b0; muldivDone = 1'b0;
      rst_n = 1'b1;
      cycles = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [31:0] badInstr [6];
      badInstr = '{32'h00000000, 32'h402091B3, 32'h0020A463, 32'h0080B283, 32'h0020B223, 32'h042081B3};

      expFetch     = packOut(1, 0, 0, 0, 1, 1, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00);
      expFetchWait = packOut(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00);
      expIdle      = 18'h0;
      expWbAlu     = packOut(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'd0, 2'b00, 2'b00);
      expWbLoad    = packOut(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'd0, 2'b01, 2'b00);
      expWbLink    = packOut(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'd0, 2'b10, 2'b00);
      expWbMd      = packOut(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'd0, 2'b11, 2'b00);

      // Cycle-by-cycle program; ALU codes ADD=0 SUB=1 SLT=3 SLTU=4 SRA=7 AND=9
      addAlu("add",   32'h002081B3, exOut(2'b00, 0, 4'd0, 0, 2'b00));
      addAlu("sub",   32'h402081B3, exOut(2'b00, 0, 4'd1, 0, 2'b00));
      addAlu("addi",  32'h00500093, exOut(2'b00, 1, 4'd0, 0, 2'b00));
      addAlu("and",   32'h0020F1B3, exOut(2'b00, 0, 4'd9, 0, 2'b00));
      addAlu("srai",  32'h4030D093, exOut(2'b00, 1, 4'd7, 0, 2'b00));
      addAlu("lui",   32'h123452B7, exOut(2'b10, 1, 4'd0, 0, 2'b00));
      addAlu("auipc", 32'h00001297, exOut(2'b01, 1, 4'd0, 0, 2'b00));
      addVec("lw fetch",  32'h0080A283, 1, 0, 0, 0, expFetch);
      addVec("lw decode", 32'h0080A283, 0, 0, 0, 0, expIdle);
      addVec("lw exec",   32'h0080A283, 0, 0, 0, 0, exOut(2'b00, 1, 4'd0, 0, 2'b00));
      for (int i = 0; i < 3; i++)
         addVec("lw mem wait", 32'h0080A283, 0, 0, 0, 0, packOut(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00));
      addVec("lw mem done", 32'h0080A283, 0, 1, 0, 0, packOut(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00));
      addVec("lw wb",       32'h0080A283, 0, 0, 0, 0, expWbLoad);
      addVec("sw fetch",  32'h0020A223, 1, 0, 0, 0, expFetch);
      addVec("sw decode", 32'h0020A223, 0, 0, 0, 0, expIdle);
      addVec("sw exec",   32'h0020A223, 0, 0, 0, 0, exOut(2'b00, 1, 4'd0, 0, 2'b00));
      addVec("sw mem",    32'h0020A223, 0, 1, 0, 0, packOut(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00));
      addVec("beq t fetch",  32'h00208463, 1, 0, 1, 0, expFetch);
      addVec("beq t decode", 32'h00208463, 0, 0, 1, 0, expIdle);
      addVec("beq t exec",   32'h00208463, 0, 0, 1, 0, exOut(2'b00, 0, 4'd1, 1, 2'b01));
      addVec("beq n fetch",  32'h00208463, 1, 0, 0, 0, expFetch);
      addVec("beq n decode", 32'h00208463, 0, 0, 0, 0, expIdle);
      addVec("beq n exec",   32'h00208463, 0, 0, 0, 0, exOut(2'b00, 0, 4'd1, 0, 2'b01));
      addVec("blt fetch",  32'h0020C463, 1, 0, 0, 0, expFetch);
      addVec("blt decode", 32'h0020C463, 0, 0, 0, 0, expIdle);
      addVec("blt exec",   32'h0020C463, 0, 0, 0, 0, exOut(2'b00, 0, 4'd3, 0, 2'b01));
      addVec("bltu fetch",  32'h0020E463, 1, 0, 1, 0, expFetch);
      addVec("bltu decode", 32'h0020E463, 0, 0, 1, 0, expIdle);
      addVec("bltu exec",   32'h0020E463, 0, 0, 1, 0, exOut(2'b00, 0, 4'd4, 1, 2'b01));
      addVec("jal fetch",  32'h010000EF, 1, 0, 0, 0, expFetch);
      addVec("jal decode", 32'h010000EF, 0, 0, 0, 0, expIdle);
      addVec("jal exec",   32'h010000EF, 0, 0, 0, 0, exOut(2'b00, 0, 4'd0, 1, 2'b01));
      addVec("jal wb",     32'h010000EF, 0, 0, 0, 0, expWbLink);
      addVec("jalr fetch",  32'h000100E7, 1, 0, 0, 0, expFetch);
      addVec("jalr decode", 32'h000100E7, 0, 0, 0, 0, expIdle);
      addVec("jalr exec",   32'h000100E7, 0, 0, 0, 0, exOut(2'b00, 1, 4'd0, 1, 2'b10));
      addVec("jalr wb",     32'h000100E7, 0, 0, 0, 0, expWbLink);
      addVec("ifetch wait1", 32'h002081B3, 0, 0, 0, 0, expFetchWait);
      addVec("ifetch wait2", 32'h002081B3, 0, 0, 0, 0, expFetchWait);
      addAlu("add2", 32'h002081B3, exOut(2'b00, 0, 4'd0, 0, 2'b00));
      addVec("mul fetch",  32'h022081B3, 1, 0, 0, 0, expFetch);
      addVec("mul decode", 32'h022081B3, 0, 0, 0, 0, expIdle);
      addVec("mul exec early done", 32'h022081B3, 0, 0, 0, 1,
             packOut(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 4'd0, 2'b00, 2'b00));
      for (int i = 0; i < 4; i++)
         addVec("mul wait", 32'h022081B3, 0, 0, 0, 0, expIdle);
      addVec("mul wait done", 32'h022081B3, 0, 0, 0, 1, expIdle);
      addVec("mul wb",        32'h022081B3, 0, 0, 0, 0, expWbMd);

      $display("[TB] starting directed program, %0d vectors", vecs.size());
      doReset();
      foreach (vecs[i]) runVec(vecs[i]);

      // 17 retirements on the M instance; the base instance trapped on mul after 16 (4-bit wrap to 0)
      checkOutput("instret M program", {32'h0, busM.instret_cnt}, 64'd17);
      checkOutput("cycle M program", {32'h0, busM.cycle_cnt}, 64'(cycles));
      checkOutput("illegal M program", {63'h0, busM.illegal_instr}, 64'd0);
      checkOutput("illegal N mul", {63'h0, busN.illegal_instr}, 64'd1);
      checkOutput("instret N mul", {60'h0, busN.instret_cnt}, 64'd0);
      checkOutput("cycle N program", {60'h0, busN.cycle_cnt}, 64'(cycles % 16));
      imemReady = 1'b1;
      repeat (3) begin
         @(negedge clk);
         cycles++;
      end
      #1;
      checkOutput("illegal N sticky", {63'h0, busN.illegal_instr}, 64'd1);
      checkOutput("imem_req N trapped", {63'h0, busN.imem_req}, 64'd0);
      checkOutput("cycle N trapped", {60'h0, busN.cycle_cnt}, 64'(cycles % 16));

      // Illegal encodings on the M instance trap after decode and never fetch again
      foreach (badInstr[k]) begin
         doReset();
         runVec(mkVec("bad fetch", badInstr[k], 1, 0, 0, 0, expFetch));
         runVec(mkVec("bad decode", badInstr[k], 1, 0, 0, 0, expIdle));
         #1;
         checkOutput($sformatf("trap illegal %0d", k), {63'h0, busM.illegal_instr}, 64'd1);
         runVec(mkVec("trap outputs", badInstr[k], 1, 1, 1, 1, expIdle));
         checkOutput($sformatf("trap instret %0d", k), {32'h0, busM.instret_cnt}, 64'd0);
      end

      // Reset dropped in the middle of a data access
      doReset();
      runVec(mkVec("rst lw fetch", 32'h0080A283, 1, 0, 0, 0, expFetch));
      runVec(mkVec("rst lw decode", 32'h0080A283, 0, 0, 0, 0, expIdle));
      runVec(mkVec("rst lw exec", 32'h0080A283, 0, 0, 0, 0, exOut(2'b00, 1, 4'd0, 0, 2'b00)));
      #1;
      checkOutput("rst dmem_req before", {63'h0, busM.dmem_req}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst dmem_req dropped", {63'h0, busM.dmem_req}, 64'd0);
      checkOutput("rst counters cleared", {busM.cycle_cnt, busM.instret_cnt}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst imem_req after release", {63'h0, busM.imem_req}, 64'd1);
      @(negedge clk);

      // 4-bit counter wrap on the base instance
      doReset();
      for (int i = 0; i < 15; i++)
         runVec(mkVec("wrap idle", 32'h002081B3, 0, 0, 0, 0, expFetchWait));
      checkOutput("cycle N at 15", {60'h0, busN.cycle_cnt}, 64'd15);
      runVec(mkVec("wrap idle", 32'h002081B3, 0, 0, 0, 0, expFetchWait));
      checkOutput("cycle N wrapped", {60'h0, busN.cycle_cnt}, 64'd0);
      checkOutput("cycle M at 16", {32'h0, busM.cycle_cnt}, 64'd16);
      for (int i = 0; i < 16; i++) begin
         runVec(mkVec("wrap add fetch", 32'h002081B3, 1, 0, 0, 0, expFetch));
         runVec(mkVec("wrap add decode", 32'h002081B3, 0, 0, 0, 0, expIdle));
         runVec(mkVec("wrap add exec", 32'h002081B3, 0, 0, 0, 0, expIdle));
         runVec(mkVec("wrap add wb", 32'h002081B3, 0, 0, 0, 0, expWbAlu));
         checkOutput($sformatf("instret N after %0d", i + 1), {60'h0, busN.instret_cnt}, 64'((i + 1) % 16));
      end
      checkOutput("instret M after 16", {32'h0, busM.instret_cnt}, 64'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
